i2s_tx_serializer: RTL and testbench

- Audio output stage directly downstream of the codec clock generator.
- Takes stereo PCM samples over a valid/ready handshake and serializes them onto sdata in Philips I2S format.
- Bit timing comes purely from the generator's free-running sequence count `seq`, so sdata stays edge-aligned with the generator's sclk/lrck.
- Sits between the filter datapath and the codec pins.

---
 rtl/i2s_tx_serializer.sv | 142 ++++++++++++++
 tb/tb_i2s_tx_serializer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer
//
// Serializes stereo PCM sample pairs onto a Philips I2S data line. Bit timing
// is decoded entirely from the codec clock generator's free-running sequence
// count, so sdata stays edge-aligned with the generator's sclk/lrck and the
// block re-aligns immediately on any jump in seq.
//
// Frame layout (512 clocks, 64 slots of 8 clocks each):
//   seq[8]   : channel, 0 = left (lrck low), 1 = right
//   seq[7:3] : sub-slot s within the channel half
//   s == 0            -> 0 (I2S one-bit delay)
//   1 <= s <= DATA_W  -> sample bit DATA_W-s (MSB first)
//   s >  DATA_W       -> 0 (padding)
//
// Ports:
//   clock         system clock, shared with the clock generator
//   reset         synchronous, active-high
//   seq           generator sequence count (only seq[8:0] decoded)
//   in_valid      sample pair offered
//   in_ready      one-entry holding buffer is free
//   in_left       left sample, two's complement
//   in_right      right sample, two's complement
//   mute          sampled at frame load; transmits zeros for that frame
//   sdata         serial data to the codec
//   frame_start   one-cycle pulse after each frame load
//   underrun      one-cycle pulse after a frame load with nothing pending
//   underrun_cnt  saturating count of underruns

module i2s_tx_serializer #(
    parameter int DATA_W = 24,
    parameter int SEQ_W  = 11,
    parameter int UCNT_W = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [SEQ_W-1:0]         seq,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_left,
    input  logic signed [DATA_W-1:0] in_right,
    input  logic                     mute,
    output logic                     sdata,
    output logic                     frame_start,
    output logic                     underrun,
    output logic [UCNT_W-1:0]        underrun_cnt
);

    // Timing decode straight from seq; no timing state is kept here.
    logic [8:0] frame_pos;
    logic       slot_edge;
    logic       frame_load;
    logic       chan_right;
    logic [4:0] sub_slot;

    assign frame_pos  = seq[8:0];
    assign slot_edge  = (frame_pos[2:0] == 3'd0);
    assign frame_load = (frame_pos == 9'd0);
    assign chan_right = frame_pos[8];
    assign sub_slot   = frame_pos[7:3];

    // Upper seq bits belong to the generator and are not needed here.
    logic unused_seq_hi;
    assign unused_seq_hi = ^seq[SEQ_W-1:9];

    logic signed [DATA_W-1:0] hold_left;
    logic signed [DATA_W-1:0] hold_right;
    logic                     hold_full;
    logic signed [DATA_W-1:0] active_left;
    logic signed [DATA_W-1:0] active_right;
    logic                     accept;

    assign in_ready = !hold_full && !reset;
    assign accept   = in_valid && in_ready;

    // Bit transmitted in sub-slot s of one channel half: delay slot, MSB-first
    // data, then zero padding.
    function automatic logic slot_bit(input logic [DATA_W-1:0] word,
                                      input logic [4:0]        s);
        logic [DATA_W-1:0] shifted;
        if (s == 5'd0 || int'(s) > DATA_W) begin
            return 1'b0;
        end
        shifted = word << (s - 5'd1);
        return shifted[DATA_W-1];
    endfunction

    // Holding buffer data: only meaningful while hold_full is set, so it
    // needs no reset.
    always_ff @(posedge clock) begin
        if (accept) begin
            hold_left  <= in_left;
            hold_right <= in_right;
        end
    end

    // Control, active frame and serializer.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_full    <= 1'b0;
            active_left  <= '0;
            active_right <= '0;
            sdata        <= 1'b0;
            frame_start  <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;

            if (frame_load) begin
                frame_start <= 1'b1;
                if (hold_full) begin
                    // Mute still consumes the pending pair so the upstream
                    // stream keeps its pace.
                    hold_full    <= 1'b0;
                    active_left  <= mute ? '0 : hold_left;
                    active_right <= mute ? '0 : hold_right;
                end else begin
                    active_left  <= '0;
                    active_right <= '0;
                    underrun     <= 1'b1;
                    if (underrun_cnt != '1) begin
                        underrun_cnt <= underrun_cnt + UCNT_W'(1);
                    end
                end
            end

            // Only possible when the buffer was empty, so it never collides
            // with the consume above; a load-cycle accept waits a frame.
            if (accept) begin
                hold_full <= 1'b1;
            end

            // At the load edge s == 0, so the stale active value is never
            // emitted.
            if (slot_edge) begin
                sdata <= slot_bit(chan_right ? active_right : active_left, sub_slot);
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
module tb_i2s_tx_serializer;

    localparam int DW = 24;
    localparam int SW = 11;
    localparam int UW = 8;

    logic          clock;
    logic          reset;
    logic [SW-1:0] seq;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_left;
    logic [DW-1:0] in_right;
    logic          mute;
    logic          sdata;
    logic          frame_start;
    logic          underrun;
    logic [UW-1:0] underrun_cnt;

    i2s_tx_serializer #(.DATA_W(DW), .SEQ_W(SW), .UCNT_W(UW)) dut (
        .clock        (clock),
        .reset        (reset),
        .seq          (seq),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_left      (in_left),
        .in_right     (in_right),
        .mute         (mute),
        .sdata        (sdata),
        .frame_start  (frame_start),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        bit            ur;
        int            cnt;
    } frame_t;

    frame_t sb[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    // Reference state: at most one pending pair, underrun tally.
    bit            m_full = 0;
    logic [DW-1:0] m_l = '0;
    logic [DW-1:0] m_r = '0;
    int            m_cnt = 0;
    bit            last_accept = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected line value in a given slot (0..63) of a transmitted frame.
    function automatic bit exp_bit(input frame_t f, input int slot);
        logic [DW-1:0] w;
        int s;
        w = (slot >= 32) ? f.r : f.l;
        s = slot % 32;
        if (s < 1 || s > DW) return 1'b0;
        return w[DW - s];
    endfunction

    // Applies the block's rules to the inputs about to be sampled.
    task automatic model_edge();
        bit exp_ready;
        frame_t f;
        exp_ready = !reset && !m_full;
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        last_accept = 0;
        if (reset) begin
            m_full = 0;
            m_cnt  = 0;
        end else begin
            if (seq[8:0] == 9'd0) begin
                f.l  = (m_full && !mute) ? m_l : '0;
                f.r  = (m_full && !mute) ? m_r : '0;
                f.ur = !m_full;
                if (!m_full && m_cnt < (1 << UW) - 1) m_cnt++;
                f.cnt = m_cnt;
                sb.push_back(f);
                m_full = 0;
            end
            if (in_valid && exp_ready) begin
                m_full = 1;
                m_l = in_left;
                m_r = in_right;
                last_accept = 1;
            end
        end
    endtask

    // One clock: model sees the settled inputs, then seq advances.
    task automatic clk_step();
        #1;
        model_edge();
        @(posedge clock);
        #1;
        seq = {2'b00, seq[8:0] + 9'd1};
    endtask

    task automatic offer(input logic [DW-1:0] l, input logic [DW-1:0] r);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_left  = l;
        in_right = r;
        do begin
            clk_step();
            n++;
        end while (!last_accept && n < 1200);
        in_valid = 1'b0;
        if (!last_accept) begin
            n_checks++;
            n_fail++;
            $display("FAIL offer_timeout: got no accept after %0d cycles, required accept", n);
        end
    endtask

    task automatic run_to_load();
        int n;
        n = 0;
        while (seq[8:0] != 9'd0 && n < 600) begin
            clk_step();
            n++;
        end
    endtask

    // Monitor: pops an expected frame at every frame_start and follows sdata.
    initial begin
        frame_t cur;
        bit active;
        bit r_prev;
        bit rs;
        int pos;
        active = 0;
        r_prev = 1;
        pos = 0;
        cur.l = '0; cur.r = '0; cur.ur = 0; cur.cnt = 0;
        forever begin
            @(negedge clock);
            rs = r_prev;
            r_prev = reset;
            if (rs) begin
                check("rst_sdata", {31'd0, sdata}, 32'd0);
                check("rst_frame_start", {31'd0, frame_start}, 32'd0);
                check("rst_underrun", {31'd0, underrun}, 32'd0);
                check("rst_underrun_cnt", {24'd0, underrun_cnt}, 32'd0);
                active = 0;
            end else begin
                if (frame_start === 1'b1) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_frame: got frame_start, required none");
                        active = 0;
                    end else begin
                        cur = sb.pop_front();
                        check("underrun_flag", {31'd0, underrun}, {31'd0, cur.ur});
                        check("underrun_cnt", {24'd0, underrun_cnt}, cur.cnt);
                        active = 1;
                        pos = 0;
                    end
                end else if (underrun !== 1'b0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL stray_underrun: got %b without frame_start, required 0", underrun);
                end
                if (active) begin
                    check($sformatf("sdata_slot%0d", pos / 8), {31'd0, sdata},
                          {31'd0, exp_bit(cur, pos / 8)});
                    pos++;
                    if (pos == 512) active = 0;
                end else begin
                    check("sdata_idle", {31'd0, sdata}, 32'd0);
                end
            end
        end
    end

    initial begin
        reset    = 1'b1;
        seq      = '0;
        in_valid = 1'b0;
        in_left  = '0;
        in_right = '0;
        mute     = 1'b0;
        repeat (3) clk_step();
        reset = 1'b0;

        // Known pattern, then two idle frames of underrun.
        offer(24'hA50F3C, 24'h800001);
        run_to_load();
        clk_step();
        repeat (1024) clk_step();
        check("ucnt_two", {24'd0, underrun_cnt}, 32'd2);

        // Back-to-back loads from seq jumping 0,1,0,1: saturate the counter.
        for (int i = 0; i < 600; i++) begin
            seq = (i % 2 == 0) ? 11'd0 : 11'd1;
            clk_step();
        end
        check("ucnt_saturated", {24'd0, underrun_cnt}, 32'd255);

        // Backpressure: second pair waits for the load edge.
        offer(24'h123456, 24'hFEDCBA);
        offer(24'h0F0F0F, 24'hF0F0F0);
        run_to_load();
        clk_step();
        run_to_load();
        clk_step();

        // Accept exactly in the load cycle with the buffer empty.
        run_to_load();
        in_valid = 1'b1;
        in_left  = 24'hC3C3C3;
        in_right = 24'h3C3C3C;
        clk_step();
        in_valid = 1'b0;
        run_to_load();
        clk_step();

        // Mute at load with a full-scale pair pending.
        offer(24'h7FFFFF, 24'h7FFFFF);
        run_to_load();
        mute = 1'b1;
        clk_step();
        mute = 1'b0;
        run_to_load();
        clk_step();

        // Reset mid-frame with a pair pending.
        offer(24'h55AA55, 24'hAA55AA);
        while (seq[8:0] != 9'd100) clk_step();
        reset = 1'b1;
        repeat (3) clk_step();
        reset = 1'b0;
        run_to_load();
        clk_step();

        // Randomized traffic with random gaps.
        for (int i = 0; i < 20; i++) begin
            int gap;
            offer(DW'($urandom), DW'($urandom));
            gap = $urandom_range(0, 700);
            repeat (gap) clk_step();
        end

        repeat (1100) clk_step();
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
